// File: rtl/tick_sched_pkg.sv
// Shared types and helpers for the tick scheduler.
// Widths that depend on module parameters are computed by constant functions, and the
// packet field extractors work on a wide bus so that any PKT_SIZE up to MaxPktW can use them.
package tick_sched_pkg;

  localparam int unsigned MaxPktW = 64;
  localparam int unsigned MaxDlyW = 8;

  // Wide slot index; callers size-cast down to their own DLY_W.
  typedef logic [MaxDlyW-1:0] slot_idx_t;
  typedef logic [MaxPktW-1:0] pkt_bus_t;

  function automatic int unsigned dly_w(input int unsigned granularity);
    return $clog2(granularity);
  endfunction

  function automatic int unsigned payload_w(input int unsigned pkt_size,
                                            input int unsigned granularity);
    return pkt_size - dly_w(granularity);
  endfunction

  // Delay field sits in the top DLY_W bits of the packet.
  function automatic slot_idx_t pkt_delay(input pkt_bus_t pkt, input int unsigned pkt_size,
                                          input int unsigned granularity);
    pkt_bus_t sh;
    sh = pkt >> payload_w(pkt_size, granularity);
    return slot_idx_t'(sh) & slot_idx_t'(granularity - 1);
  endfunction

  function automatic pkt_bus_t pkt_payload(input pkt_bus_t pkt, input int unsigned pkt_size,
                                           input int unsigned granularity);
    pkt_bus_t mask;
    mask = (pkt_bus_t'(1) << payload_w(pkt_size, granularity)) - pkt_bus_t'(1);
    return pkt & mask;
  endfunction

  // Modular slot arithmetic; granularity is a power of two.
  function automatic slot_idx_t slot_add(input slot_idx_t a, input slot_idx_t b,
                                         input int unsigned granularity);
    return (a + b) & slot_idx_t'(granularity - 1);
  endfunction

endpackage

// File: rtl/tick_scheduler_if.sv
// Router-side and controller-side valid/ready handshakes of the tick scheduler.
//   in_valid/in_ready/router_packet          : router -> scheduler, {delay, payload}
//   out_valid/out_ready/send_to_controller   : scheduler -> controller, payload only
// master = router/controller side, slave = scheduler.
interface tick_scheduler_if
  import tick_sched_pkg::*;
#(
  parameter int unsigned PKT_SIZE    = 32,
  parameter int unsigned GRANULARITY = 4
) ();

  localparam int unsigned PayloadW = payload_w(PKT_SIZE, GRANULARITY);

  logic                in_valid;
  logic                in_ready;
  logic [PKT_SIZE-1:0] router_packet;
  logic                out_valid;
  logic                out_ready;
  logic [PayloadW-1:0] send_to_controller;

  modport master (
    output in_valid, router_packet, out_ready,
    input  in_ready, out_valid, send_to_controller
  );

  modport slave (
    input  in_valid, router_packet, out_ready,
    output in_ready, out_valid, send_to_controller
  );

endinterface

// File: rtl/sched_slot_fifo.sv
// One time slot of the scheduler: a power-of-two deep FIFO with synchronous flush.
//   clk, rst          : clock, synchronous active-high reset
//   push, push_data   : write (ignored when full or flushing)
//   pop               : drop the head entry (ignored when empty or flushing)
//   flush             : empty the FIFO; overrides push and pop
//   head              : current head entry (valid when !empty)
//   full, empty, count: occupancy status
module sched_slot_fifo #(
  parameter int unsigned Width = 30,
  parameter int unsigned Depth = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [Width-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [Width-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]   count_q, count_d;
  logic             push_en, pop_en;

  assign full    = (count_q == (AddrW + 1)'(Depth));
  assign empty   = (count_q == '0);
  assign push_en = push && !full && !flush;
  assign pop_en  = pop && !empty && !flush;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + AddrW'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + AddrW'(1);
      unique case ({push_en, pop_en})
        2'b10:   count_d = count_q + (AddrW + 1)'(1);
        2'b01:   count_d = count_q - (AddrW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/tick_scheduler.sv
// Time-slotted spike scheduler between router and core controller.
// Each packet is parked in slot (cur_slot + delay) and released to the controller while
// that slot is the draining one. A registered output stage decouples the controller.
//   clk, rst     : clock, synchronous active-high reset
//   tick         : global tick pulse; advances cur_slot
//   bus          : router input and controller output handshakes (slave modport)
//   cur_slot     : slot currently draining
//   drop_count   : saturating count of overflow-rejected and stale-flushed packets
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int unsigned N_COUNT     = 256,
  parameter int unsigned GRANULARITY = 4,
  parameter int unsigned PKT_SIZE    = 32,
  parameter int unsigned SLOT_DEPTH  = 8,
  parameter int unsigned DROP_STALE  = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tick,
  tick_scheduler_if.slave                bus,
  output logic [$clog2(GRANULARITY)-1:0] cur_slot,
  output logic [CNT_W-1:0]               drop_count
);

  localparam int unsigned DlyW     = dly_w(GRANULARITY);
  localparam int unsigned PayloadW = payload_w(PKT_SIZE, GRANULARITY);
  localparam int unsigned OccW     = $clog2(SLOT_DEPTH) + 1;

  if (GRANULARITY < 2 || (GRANULARITY & (GRANULARITY - 1)) != 0 ||
      DlyW > MaxDlyW) begin : g_bad_granularity
    $error("GRANULARITY must be a power of two >= 2");
  end
  if (SLOT_DEPTH < 2 || (SLOT_DEPTH & (SLOT_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("SLOT_DEPTH must be a power of two >= 2");
  end
  if (PKT_SIZE > MaxPktW || $clog2(N_COUNT) > PayloadW) begin : g_bad_pkt
    $error("PKT_SIZE too large or payload too narrow for the neuron id");
  end
  if (OccW > CNT_W + 1) begin : g_bad_cnt
    $error("CNT_W too narrow for a full-slot flush");
  end

  logic [DlyW-1:0]     cur_slot_q, cur_slot_d;
  logic [DlyW-1:0]     target;
  logic [PayloadW-1:0] in_payload;

  logic [GRANULARITY-1:0] push, pop, flush, full, empty;
  logic [PayloadW-1:0]    head  [GRANULARITY];
  logic [OccW-1:0]        count [GRANULARITY];

  logic                accept, load_ok, pop_en, bypass, overflow;
  logic                out_valid_q, out_valid_d;
  logic [PayloadW-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]    drop_q, drop_d;
  logic [OccW-1:0]     drop_inc;
  logic [CNT_W:0]      drop_sum;

  assign target = DlyW'(slot_add(slot_idx_t'(cur_slot_q),
                                 pkt_delay(pkt_bus_t'(bus.router_packet), PKT_SIZE, GRANULARITY),
                                 GRANULARITY));
  assign in_payload = PayloadW'(pkt_payload(pkt_bus_t'(bus.router_packet), PKT_SIZE,
                                            GRANULARITY));

  // Packets arriving in a tick cycle are held off, not dropped: the router retries against
  // the new cur_slot.
  assign bus.in_ready = !rst && !tick && !full[target];
  assign accept       = bus.in_valid && bus.in_ready;
  assign overflow     = bus.in_valid && !rst && !tick && full[target];

  assign load_ok = !out_valid_q || bus.out_ready;
  assign pop_en  = !empty[cur_slot_q] && load_ok;
  // Same-tick packet into an empty draining slot goes straight to the output register,
  // giving one-cycle latency; an empty slot means FIFO order is not violated.
  assign bypass  = accept && (target == cur_slot_q) && empty[cur_slot_q] && load_ok;

  always_comb begin
    push  = '0;
    pop   = '0;
    flush = '0;
    push[target]      = accept && !bypass;
    pop[cur_slot_q]   = pop_en;
    flush[cur_slot_q] = tick && (DROP_STALE != 0);
  end

  for (genvar g = 0; g < GRANULARITY; g++) begin : g_slot
    sched_slot_fifo #(
      .Width (PayloadW),
      .Depth (SLOT_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[g]),
      .push_data (in_payload),
      .pop       (pop[g]),
      .flush     (flush[g]),
      .head      (head[g]),
      .full      (full[g]),
      .empty     (empty[g]),
      .count     (count[g])
    );
  end

  // Overflow needs !tick and a flush needs tick, so at most one source per cycle.
  // A pop coinciding with the flush has already moved its entry to the output register.
  always_comb begin
    drop_inc = '0;
    if (overflow) begin
      drop_inc = OccW'(1);
    end else if (tick && (DROP_STALE != 0)) begin
      drop_inc = count[cur_slot_q] - OccW'(pop_en);
    end
    drop_sum = {1'b0, drop_q} + (CNT_W + 1)'(drop_inc);
    drop_d   = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (bypass) begin
      out_valid_d = 1'b1;
      out_data_d  = in_payload;
    end else if (pop_en) begin
      out_valid_d = 1'b1;
      out_data_d  = head[cur_slot_q];
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  assign cur_slot_d = tick ? cur_slot_q + DlyW'(1) : cur_slot_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_slot_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      drop_q      <= '0;
    end else begin
      cur_slot_q  <= cur_slot_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.out_valid          = out_valid_q;
  assign bus.send_to_controller = out_data_q;
  assign cur_slot               = cur_slot_q;
  assign drop_count             = drop_q;

endmodule
